// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: steps a 4-column keypad through an external column
// shift register, samples the synchronised rows, debounces a single key press
// and release, and hands the accepted key to a consumer through a
// valid/acknowledge pair. One key at a time; other rows are ignored while a
// key is being tracked.
module keypad_scan_ctrl #(
    parameter int DWELL    = 4,   // cycles a column is held before rows are sampled (3..15)
    parameter int DEBOUNCE = 8    // consecutive stable samples for press and release (2..255)
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] row_in,
    input  logic [1:0] column_index,
    output logic       scan_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_pressed
);

    typedef enum logic [2:0] {
        S_SETTLE,
        S_STEP,
        S_DEBOUNCE,
        S_VALID,
        S_RELEASE
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] row_meta_q;
    logic [3:0] row_s_q;
    logic [1:0] row_idx_q;
    logic [1:0] col_q;
    logic       scan_en_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_pressed_q;

    logic [1:0] row_idx_d;
    logic [7:0] cnt_inc_d;
    logic       row_hit_d;

    // Two-flop synchroniser; the raw rows are asynchronous to the scan clock.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'h0;
            row_s_q    <= 4'h0;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
        end
    end

    // Lowest active row index, saturating counter increment, captured-row sample.
    always_comb begin
        row_idx_d = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_s_q[i]) row_idx_d = 2'(i);
        end
        cnt_inc_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        row_hit_d = row_s_q[row_idx_q];
    end

    // Scan / debounce / hand-off FSM with registered outputs.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_SETTLE;
            cnt_q         <= 8'd0;
            row_idx_q     <= 2'd0;
            col_q         <= 2'd0;
            scan_en_q     <= 1'b0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    scan_en_q <= 1'b0;
                    if (enable) begin
                        if (cnt_q == DWELL_LAST) begin
                            cnt_q <= 8'd0;
                            if (row_s_q == 4'h0) begin
                                state_q   <= S_STEP;
                                scan_en_q <= 1'b1;
                            end else begin
                                row_idx_q     <= row_idx_d;
                                col_q         <= column_index;
                                key_pressed_q <= 1'b1;
                                state_q       <= S_DEBOUNCE;
                            end
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                end
                S_STEP: begin
                    scan_en_q <= 1'b0;
                    cnt_q     <= 8'd0;
                    state_q   <= S_SETTLE;
                end
                S_DEBOUNCE: begin
                    if (row_hit_d) begin
                        if (cnt_q == DEB_LAST) begin
                            key_code_q  <= {row_idx_q, col_q};
                            key_valid_q <= 1'b1;
                            state_q     <= S_VALID;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else begin
                        // bounce: give up on this key and move to the next column
                        key_pressed_q <= 1'b0;
                        cnt_q         <= 8'd0;
                        scan_en_q     <= 1'b1;
                        state_q       <= S_STEP;
                    end
                end
                S_VALID: begin
                    if (key_ack) begin
                        key_valid_q <= 1'b0;
                        cnt_q       <= 8'd0;
                        state_q     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!row_hit_d) begin
                        if (cnt_q == DEB_LAST) begin
                            key_pressed_q <= 1'b0;
                            cnt_q         <= 8'd0;
                            scan_en_q     <= 1'b1;
                            state_q       <= S_STEP;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else begin
                        cnt_q <= 8'd0;
                    end
                end
                default: begin
                    scan_en_q <= 1'b0;
                    cnt_q     <= 8'd0;
                    state_q   <= S_SETTLE;
                end
            endcase
        end
    end

    assign scan_en     = scan_en_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, meaning cycles each column is held before rows are sampled (legal 3..15).
REQ-002 The block SHALL have parameter DEBOUNCE, default 8, meaning consecutive stable samples required for press and release (legal 2..255).
REQ-003 Port slow_clk, input, 1 bit: the only clock (1 kHz scan clock); all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port enable, input, 1 bit: scanning permitted; low freezes the column sequence.
REQ-006 Port row_in, input, 4 bits: raw keypad rows, active-high, asynchronous to slow_clk.
REQ-007 Port column_index, input, 2 bits: index of the currently driven column, from the column shift register.
REQ-008 Port scan_en, output, 1 bit: one-cycle advance pulse to the column shift register enable.
REQ-009 Port key_code, output, 4 bits: {row index, column index} of the accepted key.
REQ-010 Port key_valid, output, 1 bit: key_code holds an unacknowledged key.
REQ-011 Port key_ack, input, 1 bit: consumer acknowledge.
REQ-012 Port key_pressed, output, 1 bit: high from the start of debounce until release is confirmed.

Function
REQ-013 row_in SHALL pass through a 2-flop synchronizer (row_s); all row decisions use row_s only.
REQ-014 FSM states SHALL be SETTLE, STEP, DEBOUNCE, VALID, RELEASE; one 8-bit counter cnt.
REQ-015 SETTLE: scan_en=0; if enable=0, hold with cnt unchanged; else cnt increments and, in the cycle cnt=DWELL-1, rows are evaluated.
REQ-016 SETTLE evaluation, row_s=0: go to STEP.
REQ-017 SETTLE evaluation, row_s nonzero: capture row index (lowest set bit wins; e.g. 4'b0110 -> 1) and column_index into internal registers, clear cnt, go to DEBOUNCE.
REQ-018 STEP: scan_en=1 for exactly that one cycle, cnt cleared, next state SETTLE; scan_en SHALL never be high in any other state.
REQ-019 DEBOUNCE: key_pressed=1; each cycle the captured row bit is 1 -> cnt increments; at cnt=DEBOUNCE-1 load key_code, set key_valid, go to VALID.
REQ-020 DEBOUNCE, captured row bit reads 0 on any cycle: drop key_pressed, go to STEP (bounce rejected, scan resumes at next column).
REQ-021 VALID: key_valid=1 and key_code stable until the cycle with key_valid=1 and key_ack=1; the next cycle key_valid=0 and state RELEASE.
REQ-022 key_ack while key_valid=0 SHALL be ignored; key_ack held high SHALL not retire more than one key.
REQ-023 RELEASE: each cycle the captured row bit is 0 -> cnt increments, a 1 -> cnt clears; at cnt=DEBOUNCE-1 drop key_pressed, go to STEP.
REQ-024 Other rows changing during DEBOUNCE, VALID or RELEASE SHALL be ignored (no rollover, no second key).
REQ-025 enable SHALL affect only SETTLE; an in-progress key completes regardless of enable.
REQ-026 cnt SHALL saturate and never wrap; key_code retains its last value after release.

Reset
REQ-027 While rst=1: state=SETTLE, cnt=0, synchronizer flops=0, captured registers=0, scan_en=0, key_valid=0, key_pressed=0, key_code=4'h0.
REQ-028 Reset asserted mid-operation (any state, including VALID) SHALL drop key_valid immediately without awaiting a clock edge and discard the pending key.

Verification
REQ-029 Idle scan: enable=1, row_in=0 -> scan_en pulses once every DWELL+1 cycles (every 5 cycles with defaults); key_valid stays 0.
REQ-030 Clean press: row_in=4'b0100 while column_index=2 for 30 cycles -> key_valid=1, key_code=4'hA; key_ack -> key_valid=0 the next cycle.
REQ-031 Bounce: row high 3 cycles, then low, with DEBOUNCE=8 -> no key_valid; scan_en resumes pulsing.
REQ-032 Ack stall: key_ack held 0 for 100 cycles with the key released -> key_valid and key_code held, no scan_en; ack -> release count, then scanning resumes.
REQ-033 Multi-key: row_in=4'b1010 on column 3 -> key_code=4'h7; changing row_in to 4'b1000 in VALID leaves key_code unchanged.
REQ-034 Async reset in VALID: rst pulse between clock edges -> key_valid=0 and key_pressed=0 before the next edge; all outputs at reset values.
